// File: rtl/arb_pkg.sv
// Shared definitions for shared_port_arbiter: FSM state encoding, mux select
// codes and the timeout counter width.
package arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2,
    StTurn  = 2'd3
  } arb_state_e;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

  localparam int unsigned ARB_CNT_W = 8;

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner selection between two requesters.
//   req0_i / req1_i : requests
//   last_i          : requester granted last (1 = requester 1); loses a tie
//   valid_o         : at least one request is active
//   win1_o          : 1 when requester 1 wins, 0 when requester 0 wins
module arb_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic win1_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    win1_o  = req1_i & (~req0_i | ~last_i);
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// Two-requester arbiter/sequencer for a shared N-bit resource port.
// Grants one requester, drives the shared 2:1 mux select, holds the grant
// until port_done, and aborts a stalled grant after TIMEOUT busy cycles.
// Every grant is followed by one turnaround cycle with both grants low.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req0, req1     : requests (0 = data side, 1 = fetch side)
//   d0, d1         : requester operands
//   port_done      : resource finished the current transaction
//   gnt0, gnt1     : port ownership
//   sel            : mux select (1 = d1, 0 = d0)
//   port_data      : registered mux output
//   port_valid     : one-cycle start strobe
//   err_timeout    : one-cycle pulse when a grant is aborted
//
// Config macro SHARED_PORT_ARB_RR_EN: when defined, ties are broken
// round-robin; otherwise requester 0 always wins ties.
module shared_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         port_done,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [N-1:0] port_data,
  output logic         port_valid,
  output logic         err_timeout
);

  localparam logic [ARB_CNT_W-1:0] TimeoutCnt = ARB_CNT_W'(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 sel_q, sel_d;
  logic [N-1:0]         data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 last_gnt;
  logic                 win_valid;
  logic                 win1;

  arb_pick2 u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_gnt),
    .valid_o (win_valid),
    .win1_o  (win1)
  );

`ifdef SHARED_PORT_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && win_valid) begin
      ptr_d = win1;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign last_gnt = ptr_q;
`else
  // Fixed priority: behaving as if requester 1 was always served last.
  assign last_gnt = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = win1 ? StBusy1 : StBusy0;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          sel_d   = win1 ? SEL_D1 : SEL_D0;
          data_d  = sel_d ? d1 : d0;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StBusy0, StBusy1: begin
        if (port_done) begin
          state_d = StTurn;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StTurn;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= SEL_D0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign sel         = sel_q;
  assign port_data   = data_q;
  assign port_valid  = valid_q;
  assign err_timeout = err_q;

endmodule
